// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side handshake between a first-word-fall-through sync FIFO and the
// serial transmitter that drains it.
//   empty  : FIFO has no word available (driven by the FIFO)
//   r_data : FIFO head word, valid whenever empty==0 (driven by the FIFO)
//   rd     : one-cycle pop strobe (driven by the transmitter)
// Modports:
//   master : the transmitter, which initiates pops
//   slave  : the FIFO, which supplies data and consumes pops
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  empty;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  rd;

   modport master (
      input  empty,
      input  r_data,
      output rd
   );

   modport slave (
      output empty,
      output r_data,
      input  rd
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// UART transmitter that pops words from an upstream FWFT sync FIFO and sends
// each one as a frame: one start bit (0), DATA_WIDTH data bits LSB first, one
// stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   fifo   : FIFO read handshake (master side: drives rd, reads empty/r_data)
//   tx     : serial output, idle high, driven straight from a flop
//   busy   : high in any state other than IDLE
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic          clk,
   input  logic          reset,
   fifo_uart_tx_if.master fifo,
   output logic          tx,
   output logic          busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  tx_q,    tx_d;
   logic                  bit_end;

   // Last cycle of the current bit period.
   assign bit_end = (cnt_q == CNT_LAST);

   // The pop strobe is combinational so the word is taken in the same cycle
   // the FIFO shows it; reset masks it so nothing is popped while held.
   assign fifo.rd = (state_q == IDLE) && !fifo.empty && !reset;

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d is the line level for the next cycle, so every transition is
   // registered one cycle ahead and the start bit appears right after the pop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            tx_d  = 1'b1;
            if (!fifo.empty) begin
               shreg_d = fifo.r_data;
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = shreg_q[0];
               state_d = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shreg_d = shreg_q >> 1;
               if (idx_q == IDX_LAST) begin
                  // Index parks at the last bit; it is cleared again in IDLE.
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tx_d  = shreg_d[0];
               end
            end
         end

         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          fifo_rst;
   logic          wr;
   logic [DW-1:0] w_data;
   logic          tx;
   logic          busy;

   // Small sync FIFO, depth 8, first-word fall-through.
   logic [DW-1:0] mem [8];
   logic [2:0]    wp, rp;
   logic [3:0]    f_cnt;
   logic          full, wr_ok, rd_ok;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic full_at_c1;

   fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

   fifo_uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .fifo (fif),
      .tx   (tx),
      .busy (busy)
   );

   assign full       = (f_cnt == 4'd8);
   assign fif.empty  = (f_cnt == 4'd0);
   assign fif.r_data = mem[rp];
   assign wr_ok      = wr && !full;
   assign rd_ok      = fif.rd && !fif.empty;

   always @(posedge clk) begin
      if (fifo_rst) begin
         wp    <= 3'd0;
         rp    <= 3'd0;
         f_cnt <= 4'd0;
      end else begin
         if (wr_ok) begin
            mem[wp] <= w_data;
            wp      <= wp + 3'd1;
         end
         if (rd_ok) rp <= rp + 3'd1;
         f_cnt <= f_cnt + {3'd0, wr_ok} - {3'd0, rd_ok};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in the pop cycle; walks the 40 following cycles of one frame.
   task automatic frame(input logic [DW-1:0] d, input string tag);
      logic [9:0] bits;
      logic [9:0] exp_bits;
      int         bad;
      logic       first_tx;
      bits     = '0;
      bad      = 0;
      first_tx = 1'b1;
      exp_bits = {1'b1, d, 1'b0};
      chk({tag, "_rd_pulse"}, 32'(fif.rd), 32'd1);
      chk({tag, "_tx_at_pop"}, 32'(tx), 32'd1);
      for (int c = 1; c <= 40; c++) begin
         tick();
         wr = 1'b0;
         if (c == 1) begin
            first_tx   = tx;
            full_at_c1 = full;
         end
         if ((c - 1) % CPB == CPB / 2) bits[(c - 1) / CPB] = tx;
         if (busy !== 1'b1 || fif.rd !== 1'b0) bad++;
      end
      chk({tag, "_start_edge"}, 32'(first_tx), 32'd0);
      chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
      chk({tag, "_busy_no_rd"}, 32'(bad), 32'd0);
   endtask

   logic [DW-1:0] words [8];
   int            bad;

   initial begin
      words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h00;
      words[4] = 8'h5A; words[5] = 8'hC3; words[6] = 8'h7E; words[7] = 8'h96;

      reset    = 1'b1;
      fifo_rst = 1'b1;
      wr       = 1'b0;
      w_data   = '0;
      tick(); tick(); tick();
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd", 32'(fif.rd), 32'd0);

      // Idle with empty FIFO for 100 cycles.
      fifo_rst = 1'b0;
      reset    = 1'b0;
      bad      = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tx !== 1'b1 || fif.rd !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("idle_100", 32'(bad), 32'd0);

      // Single word 0xA5: start,1,0,1,0,0,1,0,1,stop.
      wr = 1'b1; w_data = 8'hA5;
      tick();
      wr = 1'b0;
      frame(8'hA5, "a5");
      chk("a5_exact_bits_lit", 32'({1'b1, 8'hA5, 1'b0}), 32'h34A);
      tick();
      chk("a5_empty_after", 32'(fif.empty), 32'd1);
      chk("a5_busy_after", 32'(busy), 32'd0);
      chk("a5_rd_after", 32'(fif.rd), 32'd0);

      // Fill to full while the transmitter is held in reset.
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr = 1'b1; w_data = words[i];
         tick();
      end
      wr = 1'b0;
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_rd_in_reset", 32'(fif.rd), 32'd0);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         frame(words[k], $sformatf("burst%0d", k));
         if (k == 0) chk("burst_full_drops", 32'(full_at_c1), 32'd0);
         tick();
      end
      chk("burst_empty_end", 32'(fif.empty), 32'd1);
      chk("burst_no_extra_rd", 32'(fif.rd), 32'd0);
      chk("burst_busy_end", 32'(busy), 32'd0);

      // Write and pop on the same edge with one word held.
      reset = 1'b1;
      wr = 1'b1; w_data = 8'h3A;
      tick();
      chk("simul_rd_in_reset", 32'(fif.rd), 32'd0);
      w_data = 8'hC5;
      reset  = 1'b0;
      #1;
      frame(8'h3A, "simul0");
      tick();
      frame(8'hC5, "simul1");
      tick();
      chk("simul_empty_end", 32'(fif.empty), 32'd1);
      chk("simul_busy_end", 32'(busy), 32'd0);

      // Reset in DATA bit 3 of 0x3C with 0x81 queued behind it.
      reset = 1'b1;
      wr = 1'b1; w_data = 8'h3C;
      tick();
      w_data = 8'h81;
      tick();
      wr    = 1'b0;
      reset = 1'b0;
      #1;
      chk("abort_pop", 32'(fif.rd), 32'd1);
      for (int c = 1; c <= 18; c++) begin
         tick();
         if (c == 10) chk("abort_bit1", 32'(tx), 32'd0);
      end
      chk("abort_busy_bit3", 32'(busy), 32'd1);
      chk("abort_tx_bit3", 32'(tx), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_rd_reset0", 32'(fif.rd), 32'd0);
      tick();
      chk("abort_tx_next", 32'(tx), 32'd1);
      chk("abort_busy_next", 32'(busy), 32'd0);
      chk("abort_rd_reset1", 32'(fif.rd), 32'd0);
      chk("abort_fifo_nonempty", 32'(fif.empty), 32'd0);
      tick();
      chk("abort_rd_reset2", 32'(fif.rd), 32'd0);
      reset = 1'b0;
      #1;
      frame(8'h81, "after_abort");
      tick();
      chk("abort_empty_end", 32'(fif.empty), 32'd1);
      chk("abort_no_resend", 32'(fif.rd), 32'd0);

      // Stalled writer: one word per 100 cycles.
      for (int k = 0; k < 2; k++) begin
         wr = 1'b1; w_data = (k == 0) ? 8'h55 : 8'hE7;
         tick();
         wr = 1'b0;
         frame(w_data, $sformatf("stall%0d", k));
         bad = 0;
         for (int i = 0; i < 59; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fif.rd !== 1'b0) bad++;
         end
         chk($sformatf("stall%0d_idle_gap", k), 32'(bad), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of r_data and of each serial frame's data field.
REQ-002 Parameter CLKS_PER_BIT, default 16, legal range >= 2: clk cycles per serial bit.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 empty  input  1  FIFO empty flag from the upstream sync FIFO.
REQ-006 r_data  input  DATA_WIDTH  FIFO head word, valid whenever empty==0 (first-word fall-through).
REQ-007 rd  output  1  FIFO pop strobe, one clk cycle wide.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 The block SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 IDLE: if empty==0, the block SHALL assert rd combinationally in that cycle, capture r_data into a DATA_WIDTH shift register at the clock edge, and enter START.
REQ-012 rd SHALL be asserted only in IDLE with empty==0 and reset==0; never in any other state.
REQ-013 IDLE with empty==1: rd=0, tx=1, state held.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-015 DATA: tx = shift register bit 0 (LSB first); each bit held CLKS_PER_BIT cycles; shift right and increment index after each bit; after DATA_WIDTH bits enter STOP.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then enter IDLE.
REQ-017 tx SHALL be driven from a register (glitch-free); tx=0 SHALL first appear the cycle after the rd cycle.
REQ-018 Frame period SHALL be 1 (IDLE pop cycle) + (DATA_WIDTH+2)*CLKS_PER_BIT cycles; back-to-back frames from a non-empty FIFO SHALL have no additional gap.
REQ-019 Bit-timing counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, clear on each bit boundary and on state change.
REQ-020 Bit index counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide and SHALL not wrap within a frame.
REQ-021 empty/r_data changes during START/DATA/STOP SHALL have no effect on the frame in progress.
REQ-022 busy SHALL be 1 from the cycle after the pop through the last STOP cycle, 0 in IDLE.

Reset
REQ-023 While reset==1 at a clock edge: state=IDLE, tx=1, busy=0, counters=0, shift register=0.
REQ-024 rd SHALL be 0 in any cycle where reset==1, regardless of empty.
REQ-025 Reset mid-frame SHALL abort the frame; tx=1 from the following cycle; the popped word is discarded, not re-popped.
REQ-026 After reset release, first pop SHALL occur in the first cycle with reset==0 and empty==0.

Verification (bench CLKS_PER_BIT=4, DATA_WIDTH=8, driving the real sync FIFO, depth 8)
REQ-027 Reset, empty held 1 for 100 cycles -> tx=1, rd=0, busy=0 throughout.
REQ-028 Write 0xA5 -> one rd pulse; tx samples at bit centres = 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop); frame 41 cycles including pop; empty returns 1.
REQ-029 Fill FIFO with 8 random words (full=1) -> exactly 8 rd pulses spaced 41 cycles, serial data matches write order, full deasserts after first pop, empty=1 after eighth.
REQ-030 Simultaneous FIFO write and transmitter pop on the same edge with FIFO holding 1 word -> no word lost or duplicated; serial output equals write sequence.
REQ-031 Assert reset during DATA bit 3 of 0x3C -> tx=1 next cycle, busy=0, no rd while reset high; next queued word 0x81 transmits correctly after release, 0x3C not resent.
REQ-032 Stall: write one word every 100 cycles -> each frame starts exactly 1 cycle after empty falls; tx idle-high between frames.
